mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// Handles one transaction at a time: writes take one cycle, reads wait RD_LAT cycles for data.
module mem_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       wr0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  input  logic       req1,
  input  logic       wr1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata,
  output logic [7:0] address,
  output logic [7:0] data_in,
  output logic       enable,
  output logic       write,
  input  logic [7:0] data_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

  state_t     r_state;
  logic       r_prio;
  logic       r_sel;
  logic [1:0] r_cnt;
  logic       r_gnt0, r_gnt1, r_rvalid0, r_rvalid1;
  logic       r_enable, r_write, r_busy;
  logic [7:0] r_rdata, r_address, r_data_in;

  logic w_any;
  logic w_win;

  // Contention goes to the priority holder; otherwise the lone requester wins.
  assign w_any = req0 | req1;
  assign w_win = (req0 && req1) ? r_prio : req1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_prio    <= 1'b0;
      r_sel     <= 1'b0;
      r_cnt     <= 2'd0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_enable  <= 1'b0;
      r_write   <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= 8'h00;
      r_address <= 8'h00;
      r_data_in <= 8'h00;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= ISSUE;
            r_busy    <= 1'b1;
            r_sel     <= w_win;
            r_prio    <= ~w_win;
            r_enable  <= 1'b1;
            r_write   <= w_win ? wr1 : wr0;
            r_address <= w_win ? addr1 : addr0;
            r_data_in <= w_win ? wdata1 : wdata0;
            r_gnt0    <= ~w_win;
            r_gnt1    <= w_win;
          end
        end
        ISSUE: begin
          r_enable <= 1'b0;
          r_write  <= 1'b0;
          if (r_write) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= RWAIT;
            r_cnt   <= 2'(RD_LAT);
          end
        end
        RWAIT: begin
          // Capture on the edge where the counter would reach zero.
          if (r_cnt <= 2'd1) begin
            r_cnt     <= 2'd0;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_rdata   <= data_out;
            r_rvalid0 <= ~r_sel;
            r_rvalid1 <= r_sel;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = r_rdata;
  assign address = r_address;
  assign data_in = r_data_in;
  assign enable  = r_enable;
  assign write   = r_write;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
// Both share clock, reset and a behavioural memory; each has its own requester inputs.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req0_v, wr0_v, req1_v, wr1_v;
  logic [7:0] addr0_v [2];
  logic [7:0] wdata0_v[2];
  logic [7:0] addr1_v [2];
  logic [7:0] wdata1_v[2];
  logic [1:0] gnt0_v, gnt1_v, rvalid0_v, rvalid1_v, enable_v, write_v, busy_v;
  logic [7:0] rdata_v   [2];
  logic [7:0] address_v [2];
  logic [7:0] data_in_v [2];
  logic [7:0] data_out_v[2];
  logic [7:0] mem[256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mem_arbiter #(.RD_LAT(gi == 0 ? 1 : 3)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .req0     (req0_v[gi]),
        .wr0      (wr0_v[gi]),
        .addr0    (addr0_v[gi]),
        .wdata0   (wdata0_v[gi]),
        .req1     (req1_v[gi]),
        .wr1      (wr1_v[gi]),
        .addr1    (addr1_v[gi]),
        .wdata1   (wdata1_v[gi]),
        .gnt0     (gnt0_v[gi]),
        .gnt1     (gnt1_v[gi]),
        .rvalid0  (rvalid0_v[gi]),
        .rvalid1  (rvalid1_v[gi]),
        .rdata    (rdata_v[gi]),
        .address  (address_v[gi]),
        .data_in  (data_in_v[gi]),
        .enable   (enable_v[gi]),
        .write    (write_v[gi]),
        .data_out (data_out_v[gi]),
        .busy     (busy_v[gi])
      );
      assign data_out_v[gi] = mem[address_v[gi]];
    end
  endgenerate

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++)
      if (enable_v[i] && write_v[i]) mem[address_v[i]] <= data_in_v[i];
  end

  // Mutual exclusion of grants/returns and write-implies-enable, every cycle.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      assert (!(gnt0_v[i] && gnt1_v[i])) else begin
        n_fail++;
        $error("FAIL gnt_excl[%0d]: gnt0=%0b gnt1=%0b required not both", i, gnt0_v[i], gnt1_v[i]);
      end
      n_checks++;
      assert (!(rvalid0_v[i] && rvalid1_v[i])) else begin
        n_fail++;
        $error("FAIL rvalid_excl[%0d]: rvalid0=%0b rvalid1=%0b required not both", i, rvalid0_v[i], rvalid1_v[i]);
      end
      n_checks++;
      assert (!(write_v[i] && !enable_v[i])) else begin
        n_fail++;
        $error("FAIL write_wo_enable[%0d]: write=%0b enable=%0b", i, write_v[i], enable_v[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    req0_v = '0; wr0_v = '0; req1_v = '0; wr1_v = '0;
    for (int i = 0; i < 2; i++) begin
      addr0_v[i] = 8'h00; wdata0_v[i] = 8'h00;
      addr1_v[i] = 8'h00; wdata1_v[i] = 8'h00;
    end

    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_gnt0",    {7'd0, gnt0_v[0]},   8'h00);
    chk("rst_enable",  {7'd0, enable_v[0]}, 8'h00);
    chk("rst_busy",    {7'd0, busy_v[1]},   8'h00);
    chk("rst_address", address_v[0],        8'h00);
    chk("rst_rdata",   rdata_v[1],          8'h00);

    // Write by requester 0 (RD_LAT=1 instance)
    $display("txn: inst0 req0 write addr=10 wdata=a5");
    req0_v[0] = 1'b1; wr0_v[0] = 1'b1; addr0_v[0] = 8'h10; wdata0_v[0] = 8'hA5;
    tick();
    chk("wr_enable",  {7'd0, enable_v[0]}, 8'h01);
    chk("wr_write",   {7'd0, write_v[0]},  8'h01);
    chk("wr_address", address_v[0],        8'h10);
    chk("wr_data_in", data_in_v[0],        8'hA5);
    chk("wr_gnt0",    {7'd0, gnt0_v[0]},   8'h01);
    chk("wr_gnt1",    {7'd0, gnt1_v[0]},   8'h00);
    chk("wr_busy",    {7'd0, busy_v[0]},   8'h01);
    req0_v[0] = 1'b0;
    tick();
    chk("wr_done_enable", {7'd0, enable_v[0]}, 8'h00);
    chk("wr_done_gnt0",   {7'd0, gnt0_v[0]},   8'h00);
    chk("wr_done_busy",   {7'd0, busy_v[0]},   8'h00);
    chk("wr_hold_addr",   address_v[0],        8'h10);

    // Read by requester 1, RD_LAT=1: rvalid at C+2
    $display("txn: inst0 req1 read addr=10");
    req1_v[0] = 1'b1; wr1_v[0] = 1'b0; addr1_v[0] = 8'h10;
    tick();
    chk("rd_gnt1",   {7'd0, gnt1_v[0]},   8'h01);
    chk("rd_enable", {7'd0, enable_v[0]}, 8'h01);
    chk("rd_write",  {7'd0, write_v[0]},  8'h00);
    req1_v[0] = 1'b0;
    tick();
    chk("rd_c1_enable",  {7'd0, enable_v[0]},  8'h00);
    chk("rd_c1_rvalid1", {7'd0, rvalid1_v[0]}, 8'h00);
    chk("rd_c1_busy",    {7'd0, busy_v[0]},    8'h01);
    tick();
    chk("rd_c2_rvalid1", {7'd0, rvalid1_v[0]}, 8'h01);
    chk("rd_c2_rvalid0", {7'd0, rvalid0_v[0]}, 8'h00);
    chk("rd_c2_rdata",   rdata_v[0],           8'hA5);
    tick();
    chk("rd_c3_rvalid1", {7'd0, rvalid1_v[0]}, 8'h00);
    chk("rd_c3_rdata",   rdata_v[0],           8'hA5);
    chk("rd_c3_busy",    {7'd0, busy_v[0]},    8'h00);

    // Round-robin under contention after reset: 0,1,0,1 every other cycle
    $display("txn: inst0 contention, four writes");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_v[0] = 1'b1; wr0_v[0] = 1'b1; addr0_v[0] = 8'h20; wdata0_v[0] = 8'h01;
    req1_v[0] = 1'b1; wr1_v[0] = 1'b1; addr1_v[0] = 8'h30; wdata1_v[0] = 8'h02;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d_gnt0", k), {7'd0, gnt0_v[0]}, (k % 2 == 0) ? 8'h01 : 8'h00);
      chk($sformatf("rr%0d_gnt1", k), {7'd0, gnt1_v[0]}, (k % 2 == 1) ? 8'h01 : 8'h00);
      chk($sformatf("rr%0d_addr", k), address_v[0], (k % 2 == 0) ? 8'h20 : 8'h30);
      tick();
      chk($sformatf("rr%0d_gap", k), {6'd0, gnt1_v[0], gnt0_v[0]}, 8'h00);
    end
    req0_v[0] = 1'b0; req1_v[0] = 1'b0;

    // RD_LAT=3 read with req0 re-asserted during RWAIT
    $display("txn: inst1 req0 read addr=10, RD_LAT=3");
    req0_v[1] = 1'b1; wr0_v[1] = 1'b0; addr0_v[1] = 8'h10;
    tick();
    chk("l3_gnt0",   {7'd0, gnt0_v[1]},   8'h01);
    chk("l3_enable", {7'd0, enable_v[1]}, 8'h01);
    wr0_v[1] = 1'b1; addr0_v[1] = 8'h40; wdata0_v[1] = 8'h5A;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("l3_c%0d_gnt0", k),   {7'd0, gnt0_v[1]},   8'h00);
      chk($sformatf("l3_c%0d_rvalid0", k), {7'd0, rvalid0_v[1]}, 8'h00);
    end
    tick();
    chk("l3_c4_rvalid0", {7'd0, rvalid0_v[1]}, 8'h01);
    chk("l3_c4_rdata",   rdata_v[1],           8'hA5);
    chk("l3_c4_gnt0",    {7'd0, gnt0_v[1]},    8'h00);
    tick();
    chk("l3_c5_gnt0",    {7'd0, gnt0_v[1]},    8'h01);
    chk("l3_c5_write",   {7'd0, write_v[1]},   8'h01);
    chk("l3_c5_address", address_v[1],         8'h40);
    req0_v[1] = 1'b0;
    tick();
    chk("l3_c6_gnt0",    {7'd0, gnt0_v[1]},    8'h00);

    // Reset during RWAIT: no rvalid, priority back to requester 0
    $display("txn: inst1 req0 read, reset in RWAIT");
    req0_v[1] = 1'b1; wr0_v[1] = 1'b0; addr0_v[1] = 8'h10;
    tick();
    chk("ab_gnt0", {7'd0, gnt0_v[1]}, 8'h01);
    req0_v[1] = 1'b0;
    tick();
    chk("ab_busy_rwait", {7'd0, busy_v[1]}, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_busy",    {7'd0, busy_v[1]},    8'h00);
    chk("ab_rvalid0", {7'd0, rvalid0_v[1]}, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ab_quiet%0d", k), {6'd0, rvalid1_v[1], rvalid0_v[1]}, 8'h00);
    end
    req0_v[1] = 1'b1; wr0_v[1] = 1'b1; addr0_v[1] = 8'h50; wdata0_v[1] = 8'h11;
    req1_v[1] = 1'b1; wr1_v[1] = 1'b1; addr1_v[1] = 8'h60; wdata1_v[1] = 8'h22;
    tick();
    chk("ab_prio_gnt0", {7'd0, gnt0_v[1]}, 8'h01);
    chk("ab_prio_gnt1", {7'd0, gnt1_v[1]}, 8'h00);
    req0_v[1] = 1'b0; req1_v[1] = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
